// File: rtl/regfile_bypass_sb_if.sv
`default_nettype none
// ============================================================================
// Module      : regfile_bypass_sb_if
// Description : Decode/writeback bundle for the bypassing, scoreboarded regfile.
// Revision    : 1.0 - initial release
// ============================================================================
interface regfile_bypass_sb_if #(
    parameter int WIDTH  = 32,
    parameter int DEPTH  = 32,
    parameter int NUM_RD = 2,
    parameter int NUM_WR = 2
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [NUM_RD*AW-1:0]    rd_addr;
    logic [NUM_RD*WIDTH-1:0] rd_data;
    logic [NUM_RD-1:0]       rd_busy;
    logic [NUM_WR-1:0]       wr_en;
    logic [NUM_WR*AW-1:0]    wr_addr;
    logic [NUM_WR*WIDTH-1:0] wr_data;
    logic                    alloc_en;
    logic [AW-1:0]           alloc_addr;
    logic [DEPTH-1:0]        busy_vec;

    modport master (
        output rd_addr, wr_en, wr_addr, wr_data, alloc_en, alloc_addr,
        input  rd_data, rd_busy, busy_vec
    );

    modport slave (
        input  rd_addr, wr_en, wr_addr, wr_data, alloc_en, alloc_addr,
        output rd_data, rd_busy, busy_vec
    );
endinterface
`default_nettype wire

// File: rtl/regfile_bypass_sb.sv
`default_nettype none
// ============================================================================
// Module      : regfile_bypass_sb
// Description : Multi-port register file with write bypass and busy scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_bypass_sb #(
    parameter int WIDTH     = 32,
    parameter int DEPTH     = 32,
    parameter int NUM_RD    = 2,
    parameter int NUM_WR    = 2,
    parameter int BYPASS    = 1,
    parameter int ZERO_REG0 = 1
) (
    input  wire logic          clk,
    input  wire logic          rst,
    regfile_bypass_sb_if.slave bus
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0]        r_mem [DEPTH];
    logic [DEPTH-1:0]        r_busy;
    logic [DEPTH-1:0]        w_busy_nxt;
    logic [NUM_RD*WIDTH-1:0] w_rd_data;
    logic [NUM_RD-1:0]       w_rd_busy;
    logic [AW-1:0]           w_ra;
    logic                    w_hit;
    logic [WIDTH-1:0]        w_byp;

    // An address names a real, writable entry: in range and not the hardwired zero.
    function automatic logic f_valid(input logic [AW-1:0] a);
        return (int'(a) < DEPTH) && !((ZERO_REG0 != 0) && (a == '0));
    endfunction

    // Later ports overwrite earlier ones, so the highest write port wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int e = 0; e < DEPTH; e++) begin
                r_mem[e] <= '0;
            end
        end else begin
            for (int j = 0; j < NUM_WR; j++) begin
                if (bus.wr_en[j] && f_valid(bus.wr_addr[j*AW +: AW])) begin
                    r_mem[bus.wr_addr[j*AW +: AW]] <= bus.wr_data[j*WIDTH +: WIDTH];
                end
            end
        end
    end

    // Writes retire the old producer first, then a new alloc re-marks the entry.
    always_comb begin
        w_busy_nxt = r_busy;
        for (int j = 0; j < NUM_WR; j++) begin
            if (bus.wr_en[j] && f_valid(bus.wr_addr[j*AW +: AW])) begin
                w_busy_nxt[bus.wr_addr[j*AW +: AW]] = 1'b0;
            end
        end
        if (bus.alloc_en && f_valid(bus.alloc_addr)) begin
            w_busy_nxt[bus.alloc_addr] = 1'b1;
        end
        if (ZERO_REG0 != 0) begin
            w_busy_nxt[0] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy <= '0;
        end else begin
            r_busy <= w_busy_nxt;
        end
    end

    always_comb begin
        w_rd_data = '0;
        w_rd_busy = '0;
        w_ra      = '0;
        w_hit     = 1'b0;
        w_byp     = '0;
        for (int i = 0; i < NUM_RD; i++) begin
            w_ra  = bus.rd_addr[i*AW +: AW];
            w_hit = 1'b0;
            w_byp = '0;
            if ((BYPASS != 0) && !rst) begin
                for (int j = 0; j < NUM_WR; j++) begin
                    if (bus.wr_en[j] && (bus.wr_addr[j*AW +: AW] == w_ra)) begin
                        w_hit = 1'b1;
                        w_byp = bus.wr_data[j*WIDTH +: WIDTH];
                    end
                end
            end
            if (f_valid(w_ra)) begin
                w_rd_data[i*WIDTH +: WIDTH] = w_hit ? w_byp : r_mem[w_ra];
                w_rd_busy[i]                = r_busy[w_ra] & ~w_hit;
            end
        end
    end

    assign bus.rd_data  = w_rd_data;
    assign bus.rd_busy  = w_rd_busy;
    assign bus.busy_vec = r_busy;
endmodule
`default_nettype wire

// File: tb/tb_regfile_bypass_sb.sv
`default_nettype none
// ============================================================================
// Module      : tb_regfile_bypass_sb
// Description : Two regfile instances (bypass/32 entries, no-bypass/24 entries)
//               checked against a behavioural model plus directed literals.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_bypass_sb;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [4:0]  rd_a [2];
    logic        wr_e [2];
    logic [4:0]  wr_a [2];
    logic [31:0] wr_d [2];
    logic        al_e;
    logic [4:0]  al_a;

    regfile_bypass_sb_if #(.WIDTH(32), .DEPTH(24), .NUM_RD(2), .NUM_WR(2)) bus0 ();
    regfile_bypass_sb_if #(.WIDTH(32), .DEPTH(32), .NUM_RD(2), .NUM_WR(2)) bus1 ();

    assign bus0.rd_addr    = {rd_a[1], rd_a[0]};
    assign bus0.wr_en      = {wr_e[1], wr_e[0]};
    assign bus0.wr_addr    = {wr_a[1], wr_a[0]};
    assign bus0.wr_data    = {wr_d[1], wr_d[0]};
    assign bus0.alloc_en   = al_e;
    assign bus0.alloc_addr = al_a;
    assign bus1.rd_addr    = {rd_a[1], rd_a[0]};
    assign bus1.wr_en      = {wr_e[1], wr_e[0]};
    assign bus1.wr_addr    = {wr_a[1], wr_a[0]};
    assign bus1.wr_data    = {wr_d[1], wr_d[0]};
    assign bus1.alloc_en   = al_e;
    assign bus1.alloc_addr = al_a;

    regfile_bypass_sb #(.WIDTH(32), .DEPTH(24), .NUM_RD(2), .NUM_WR(2), .BYPASS(0), .ZERO_REG0(1))
        u_dut0 (.clk(clk), .rst(rst), .bus(bus0));
    regfile_bypass_sb #(.WIDTH(32), .DEPTH(32), .NUM_RD(2), .NUM_WR(2), .BYPASS(1), .ZERO_REG0(1))
        u_dut1 (.clk(clk), .rst(rst), .bus(bus1));

    int n_checks = 0;
    int n_pass   = 0;
    bit chk_en   = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // ---------------- behavioural model: k=0 no-bypass/24, k=1 bypass/32 ----------------
    logic [31:0] m_mem  [2][32];
    bit          m_busy [2][32];

    function automatic int depth_of(input int k);
        return (k == 0) ? 24 : 32;
    endfunction

    function automatic bit real_entry(input int k, input int a);
        return (a != 0) && (a < depth_of(k));
    endfunction

    function automatic bit bypass_hit(input int k, input int a, output logic [31:0] d);
        bit hit = 1'b0;
        d = '0;
        if (k == 1 && !rst) begin
            for (int j = 0; j < 2; j++) if (wr_e[j] && int'(wr_a[j]) == a) begin hit = 1'b1; d = wr_d[j]; end
        end
        return hit;
    endfunction

    function automatic logic [31:0] exp_rd(input int k, input int i);
        logic [31:0] d;
        int a = int'(rd_a[i]);
        if (!real_entry(k, a)) return '0;
        if (bypass_hit(k, a, d)) return d;
        return m_mem[k][a];
    endfunction

    function automatic logic exp_rbusy(input int k, input int i);
        logic [31:0] d;
        int a = int'(rd_a[i]);
        if (!real_entry(k, a)) return 1'b0;
        if (bypass_hit(k, a, d)) return 1'b0;
        return m_busy[k][a];
    endfunction

    function automatic logic [31:0] exp_bvec(input int k);
        logic [31:0] v = '0;
        for (int a = 0; a < 32; a++) v[a] = m_busy[k][a];
        return v;
    endfunction

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                for (int a = 0; a < 32; a++) begin m_mem[k][a] = '0; m_busy[k][a] = 1'b0; end
            end else begin
                for (int j = 0; j < 2; j++) begin
                    if (wr_e[j] && real_entry(k, int'(wr_a[j]))) begin
                        m_mem[k][wr_a[j]]  = wr_d[j];
                        m_busy[k][wr_a[j]] = 1'b0;
                    end
                end
                if (al_e && real_entry(k, int'(al_a))) m_busy[k][al_a] = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < 2; i++) begin
                check($sformatf("m rd_data dut0 p%0d", i), bus0.rd_data[i*32 +: 32], exp_rd(0, i));
                check($sformatf("m rd_data dut1 p%0d", i), bus1.rd_data[i*32 +: 32], exp_rd(1, i));
                check($sformatf("m rd_busy dut0 p%0d", i), bus0.rd_busy[i], exp_rbusy(0, i));
                check($sformatf("m rd_busy dut1 p%0d", i), bus1.rd_busy[i], exp_rbusy(1, i));
            end
            check("m busy_vec dut0", {8'h0, bus0.busy_vec}, exp_bvec(0));
            check("m busy_vec dut1", bus1.busy_vec, exp_bvec(1));
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wr_e[0] = 1'b0; wr_e[1] = 1'b0; al_e = 1'b0;
    endtask

    task automatic wr(input int j, input logic [4:0] a, input logic [31:0] d);
        wr_e[j] = 1'b1; wr_a[j] = a; wr_d[j] = d;
    endtask

    initial begin
        idle();
        rd_a[0] = '0; rd_a[1] = '0; wr_a[0] = '0; wr_a[1] = '0;
        wr_d[0] = '0; wr_d[1] = '0; al_a = '0;
        tick(); tick();
        rst = 1'b0;
        chk_en = 1'b1;

        // reset state
        for (int a = 0; a < 32; a += 2) begin
            rd_a[0] = 5'(a); rd_a[1] = 5'(a + 1);
            #2;
            check("rst rd_data dut1 p0", bus1.rd_data[31:0], 0);
            check("rst rd_data dut1 p1", bus1.rd_data[63:32], 0);
            check("rst rd_busy dut1", bus1.rd_busy, 0);
            tick();
        end
        check("rst busy_vec dut0", bus0.busy_vec, 0);
        check("rst busy_vec dut1", bus1.busy_vec, 0);

        // single write with/without bypass
        idle(); wr(0, 5, 32'hDEADBEEF); rd_a[0] = 5; #2;
        check("byp wr5 dut1", bus1.rd_data[31:0], 32'hDEADBEEF);
        check("nobyp wr5 dut0", bus0.rd_data[31:0], 0);
        tick(); idle(); #2;
        check("stored 5 dut1", bus1.rd_data[31:0], 32'hDEADBEEF);
        check("stored 5 dut0", bus0.rd_data[31:0], 32'hDEADBEEF);

        // two ports to same address: port1 wins
        tick(); idle(); wr(0, 7, 32'h11); wr(1, 7, 32'h22); rd_a[0] = 7; #2;
        check("prio byp dut1", bus1.rd_data[31:0], 32'h22);
        check("prio nobyp dut0", bus0.rd_data[31:0], 0);
        tick(); idle(); #2;
        check("prio stored dut1", bus1.rd_data[31:0], 32'h22);
        check("prio stored dut0", bus0.rd_data[31:0], 32'h22);

        // entry 0 hardwired
        tick(); idle(); wr(0, 0, 32'h1234); rd_a[0] = 0; #2;
        check("zero byp dut1", bus1.rd_data[31:0], 0);
        tick(); idle(); al_e = 1'b1; al_a = 0; #2;
        check("zero after wr dut1", bus1.rd_data[31:0], 0);
        tick(); idle(); #2;
        check("zero busy dut1", bus1.busy_vec[0], 0);
        check("zero rd_busy dut1", bus1.rd_busy[0], 0);

        // scoreboard
        tick(); idle(); al_e = 1'b1; al_a = 3; rd_a[0] = 3; #2;
        check("alloc same-cycle rd_busy dut1", bus1.rd_busy[0], 0);
        tick(); idle(); #2;
        check("alloc busy_vec dut1", bus1.busy_vec[3], 1);
        check("alloc rd_busy dut0", bus0.rd_busy[0], 1);
        tick(); idle(); wr(0, 3, 32'h55); #2;
        check("wb byp rd_busy dut1", bus1.rd_busy[0], 0);
        check("wb nobyp rd_busy dut0", bus0.rd_busy[0], 1);
        check("wb byp data dut1", bus1.rd_data[31:0], 32'h55);
        tick(); idle(); al_e = 1'b1; al_a = 3; wr(1, 3, 32'h66); #2;
        check("wb cleared dut1", bus1.busy_vec[3], 0);
        tick(); idle(); #2;
        check("alloc+wr busy dut1", bus1.busy_vec[3], 1);
        check("alloc+wr busy dut0", bus0.busy_vec[3], 1);
        check("alloc+wr data dut0", bus0.rd_data[31:0], 32'h66);

        // reset mid-operation
        tick(); idle(); al_e = 1'b1; al_a = 1;
        tick(); al_a = 2;
        tick(); al_a = 3; wr(0, 9, 32'hAA);
        tick(); idle(); #2;
        check("pre-rst busy dut1", bus1.busy_vec, 32'h0000_000E);
        tick(); idle(); rst = 1'b1; wr(0, 4, 32'h44); rd_a[0] = 4; rd_a[1] = 9; #2;
        check("rst no-bypass dut1", bus1.rd_data[31:0], 0);
        check("rst-cycle old 9 dut1", bus1.rd_data[63:32], 32'hAA);
        tick(); rst = 1'b0; idle(); #2;
        check("post-rst busy dut1", bus1.busy_vec, 0);
        check("post-rst addr4 dut1", bus1.rd_data[31:0], 0);
        check("post-rst addr9 dut0", bus0.rd_data[63:32], 0);

        // out-of-range entries on the 24-deep instance
        tick(); idle(); wr(1, 30, 32'h77);
        tick(); idle(); al_e = 1'b1; al_a = 30; rd_a[0] = 30; #2;
        check("oor rd dut1", bus1.rd_data[31:0], 32'h77);
        check("oor rd dut0", bus0.rd_data[31:0], 0);
        tick(); idle(); #2;
        check("oor busy dut0", {8'h0, bus0.busy_vec}, 0);
        check("oor busy dut1", bus1.busy_vec, 32'h4000_0000);

        // random traffic, checked by the model every cycle
        for (int n = 0; n < 10000; n++) begin
            tick();
            rst = ($urandom_range(0, 499) == 0);
            for (int j = 0; j < 2; j++) begin
                wr_e[j] = $urandom_range(0, 1) != 0;
                wr_a[j] = 5'($urandom_range(0, 31));
                wr_d[j] = $urandom;
            end
            al_e = $urandom_range(0, 2) == 0;
            al_a = 5'($urandom_range(0, 31));
            for (int i = 0; i < 2; i++) begin
                case ($urandom_range(0, 3))
                    0:       rd_a[i] = wr_a[0];
                    1:       rd_a[i] = wr_a[1];
                    2:       rd_a[i] = al_a;
                    default: rd_a[i] = 5'($urandom_range(0, 31));
                endcase
            end
        end
        tick(); idle(); rst = 1'b0;
        tick();
        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
`default_nettype wire
